// File: rtl/mont_mul_r2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mont_mul_r2_pkg
// Description : Shared constants for the Montgomery multiplier: default width,
//               FSM state encoding and R^2 mod n for the default curve modulus.
// Revision    : 1.0 - initial release
// ============================================================================
package mont_mul_r2_pkg;

    localparam int c_max_bits = 256;

    // Same encoding style as the modular-inversion stage upstream.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_corr = 2'd2;

    // R^2 mod (2^255 - 19) with R = 2^256: R mod p = 38, so R^2 mod p = 1444.
    localparam logic [255:0] c_r2_25519 = 256'd1444;

endpackage
`default_nettype wire

// File: rtl/mont_step.sv
`default_nettype none
// ============================================================================
// Module      : mont_step
// Description : One combinational radix-2 Montgomery iteration:
//               m' = (m + a_bit*b + (odd ? n : 0)) / 2.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_step #(
    parameter int MAX_BITS = 256
) (
    input  logic [MAX_BITS+1:0] i_m,
    input  logic [MAX_BITS-1:0] i_b,
    input  logic [MAX_BITS-1:0] i_n,
    input  logic                i_a_bit,
    output logic [MAX_BITS+1:0] o_m
);

    logic [MAX_BITS+1:0] w_t0;
    logic [MAX_BITS+1:0] w_t1;

    // With m < 2n and b < n the sum stays below 4n, so two guard bits suffice.
    assign w_t0 = i_m + (i_a_bit ? {2'b00, i_b} : '0);
    assign w_t1 = w_t0 + (w_t0[0] ? {2'b00, i_n} : '0);
    assign o_m  = w_t1 >> 1;

endmodule
`default_nettype wire

// File: rtl/mont_mul_r2.sv
`default_nettype none
// ============================================================================
// Module      : mont_mul_r2
// Description : Radix-2 bit-serial Montgomery multiplier,
//               o_result = a * b * 2^-MAX_BITS mod n.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_mul_r2
    import mont_mul_r2_pkg::*;
#(
    parameter int MAX_BITS = c_max_bits
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [MAX_BITS-1:0] i_n,
    input  logic [MAX_BITS-1:0] i_a,
    input  logic [MAX_BITS-1:0] i_b,
    output logic [MAX_BITS-1:0] o_result,
    output logic                o_finished,
    output logic                o_busy
);

    localparam int              CNT_W      = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_BITS - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [MAX_BITS+1:0] r_m;
    logic [MAX_BITS+1:0] w_m_nxt;
    logic [MAX_BITS-1:0] r_a;
    logic [MAX_BITS-1:0] r_b;
    logic [CNT_W-1:0]    r_cnt;
    logic [MAX_BITS-1:0] r_result;
    logic                r_finished;
    logic                w_last;
    logic                w_ge;
    logic [MAX_BITS-1:0] w_corr;

    mont_step #(
        .MAX_BITS (MAX_BITS)
    ) u_step (
        .i_m     (r_m),
        .i_b     (r_b),
        .i_n     (i_n),
        .i_a_bit (r_a[0]),
        .o_m     (w_m_nxt)
    );

    assign w_last = (r_cnt == c_cnt_last);

    // Subtracting on the truncated low bits gives the same truncated result.
    assign w_ge   = (r_m >= {2'b00, i_n});
    assign w_corr = w_ge ? (r_m[MAX_BITS-1:0] - i_n) : r_m[MAX_BITS-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (i_start) w_state_nxt = c_st_run;
            c_st_run:  if (w_last)  w_state_nxt = c_st_corr;
            c_st_corr: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_m        <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_finished <= 1'b0;
                    if (i_start) begin
                        r_a   <= i_a;
                        r_b   <= i_b;
                        r_m   <= '0;
                        r_cnt <= '0;
                    end
                end
                c_st_run: begin
                    r_m   <= w_m_nxt;
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                c_st_corr: begin
                    r_result   <= w_corr;
                    r_finished <= 1'b1;
                end
                default: r_finished <= 1'b0;
            endcase
        end
    end

    assign o_result   = r_result;
    assign o_finished = r_finished;
    assign o_busy     = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_mont_mul_r2.sv
`default_nettype none
// ============================================================================
// Module      : tb_mont_mul_r2
// Description : Self-checking bench for mont_mul_r2 at 8 and 256 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_mul_r2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s8;
    logic [7:0]   n8, a8, b8, r8;
    logic         f8, bz8;
    logic         s256;
    logic [255:0] n256, a256, b256, r256;
    logic         f256, bz256;

    mont_mul_r2 #(.MAX_BITS(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(s8), .i_n(n8), .i_a(a8), .i_b(b8),
        .o_result(r8), .o_finished(f8), .o_busy(bz8)
    );

    mont_mul_r2 #(.MAX_BITS(256)) u_dut256 (
        .i_clk(clk), .i_rst(rst), .i_start(s256), .i_n(n256), .i_a(a256), .i_b(b256),
        .o_result(r256), .o_finished(f256), .o_busy(bz256)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Reference: the unique r in [0,n) with r*2^8 == a*b (mod n).
    function automatic logic [7:0] ref8(input int n, input int a, input int b);
        int p;
        p = (a * b) % n;
        for (int r = 0; r < n; r++)
            if (((r * 256) % n) == p) return 8'(r);
        return 8'd0;
    endfunction

    // Start one 8-bit operation; start held for 'hold' extra cycles while operands wobble.
    task automatic run8(input logic [7:0] n, input logic [7:0] a, input logic [7:0] b,
                        input int hold, output logic [7:0] res, output int lat);
        @(negedge clk);
        n8 = n; a8 = a; b8 = b; s8 = 1'b1;
        lat = -1;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            if (e == 0) check("busy8_after_start", {255'd0, bz8}, 256'd1);
            if (e >= hold) s8 = 1'b0;
            else begin a8 = ~a; b8 = ~b; end
            if (f8) begin lat = e; break; end
        end
        s8 = 1'b0;
        res = r8;
        if (lat < 0) fail_now("run8_timeout");
    endtask

    typedef struct {
        logic [7:0] n;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t         vt[5];
    logic [511:0] p, inv2, rinv, r2, x;
    logic [255:0] opa[201];
    logic [255:0] opb[201];
    logic [255:0] expv[201];

    initial begin
        logic [7:0] res;
        int         lat;
        int         rn, ra, rb;
        bit         seen;

        vt[0] = '{8'd13,  8'd1,   8'd1,   8'd3};
        vt[1] = '{8'd13,  8'd9,   8'd5,   8'd5};
        vt[2] = '{8'd13,  8'd12,  8'd12,  8'd3};
        vt[3] = '{8'd255, 8'd254, 8'd254, 8'd1};
        vt[4] = '{8'd13,  8'd0,   8'd7,   8'd0};

        rst = 1'b1; s8 = 1'b0; n8 = 8'd13; a8 = '0; b8 = '0;
        s256 = 1'b0; n256 = '0; a256 = '0; b256 = '0;
        repeat (3) @(negedge clk);
        check("rst_result8",   {248'd0, r8},  256'd0);
        check("rst_finished8", {255'd0, f8},  256'd0);
        check("rst_busy8",     {255'd0, bz8}, 256'd0);
        check("rst_result256", r256, 256'd0);
        check("rst_busy256",   {255'd0, bz256}, 256'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run8(vt[i].n, vt[i].a, vt[i].b, 0, res, lat);
            check($sformatf("vec%0d_result", i), {248'd0, res}, {248'd0, vt[i].exp});
            check($sformatf("vec%0d_latency", i), 256'(lat), 256'd9);
            @(negedge clk);
            check($sformatf("vec%0d_pulse_low", i), {255'd0, f8}, 256'd0);
        end

        for (int i = 0; i < 20; i++) begin
            rn = 2 * int'($urandom_range(1, 127)) + 1;
            ra = int'($urandom_range(0, rn - 1));
            rb = int'($urandom_range(0, rn - 1));
            run8(8'(rn), 8'(ra), 8'(rb), 0, res, lat);
            check($sformatf("rand8_%0d_n%0d_a%0d_b%0d", i, rn, ra, rb), {248'd0, res},
                  {248'd0, ref8(rn, ra, rb)});
        end

        // Start held high (and operands changing) during RUN must be ignored.
        run8(8'd13, 8'd9, 8'd5, 5, res, lat);
        check("hold_start_result", {248'd0, res}, 256'd5);
        check("hold_start_latency", 256'(lat), 256'd9);

        // Reset at cnt=4 aborts without a done pulse.
        @(negedge clk);
        n8 = 8'd13; a8 = 8'd12; b8 = 8'd12; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy",     {255'd0, bz8}, 256'd0);
        check("midrst_result",   {248'd0, r8},  256'd0);
        check("midrst_finished", {255'd0, f8},  256'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (f8) seen = 1'b1;
        end
        check("midrst_no_pulse", {255'd0, seen}, 256'd0);
        run8(8'd13, 8'd1, 8'd1, 0, res, lat);
        check("restart_result", {248'd0, res}, 256'd3);
        check("restart_latency", 256'(lat), 256'd9);

        // 256-bit model over p = 2^255 - 19 with R^-1 = (1/2)^256 mod p.
        p    = (512'd1 << 255) - 512'd19;
        inv2 = (p + 512'd1) >> 1;
        rinv = 512'd1;
        repeat (256) rinv = (rinv * inv2) % p;
        r2 = (512'd1 << 256) % p;
        r2 = (r2 * r2) % p;
        check("r2_constant", mont_mul_r2_pkg::c_r2_25519, r2[255:0]);

        for (int i = 0; i < 201; i++) begin
            x = {256'd0, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
            opa[i] = 256'(x % p);
            x = {256'd0, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
            opb[i] = (i == 200) ? r2[255:0] : 256'(x % p);
            x = ({256'd0, opa[i]} * {256'd0, opb[i]}) % p;
            x = (x * rinv) % p;
            expv[i] = x[255:0];
        end

        @(negedge clk);
        n256 = p[255:0]; a256 = opa[0]; b256 = opb[0]; s256 = 1'b1;
        for (int i = 0; i < 201; i++) begin
            lat = -1;
            for (int e = 0; e < 300; e++) begin
                @(negedge clk);
                if (e == 0) s256 = 1'b0;
                if (f256) begin lat = e; break; end
            end
            if (lat < 0) begin
                fail_now($sformatf("run256_%0d_timeout", i));
                break;
            end
            check($sformatf("mont256_%0d", i), r256, expv[i]);
            check($sformatf("lat256_%0d", i), 256'(lat), 256'd257);
            if (i < 200) begin
                a256 = opa[i+1]; b256 = opb[i+1]; s256 = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
